// File: rtl/down_timer_ctrl_pkg.sv
// down_timer_ctrl_pkg
// Shared types and constants for the down timer controller slice.
//   DEF_WIDTH : default count width in bits
//   state_t   : controller FSM state encoding (IDLE, RUN, DONE)
package down_timer_ctrl_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/down_timer_ctrl_if.sv
// down_timer_ctrl_if
// Control/status bundle between a timer user and down_timer_ctrl.
//   start, stop, load_val : requests from the user (master drives)
//   q, busy, tc, done     : registered status from the timer (slave drives)
interface down_timer_ctrl_if
    import down_timer_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             start;
    logic             stop;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             tc;
    logic             done;

    modport master (
        output start, stop, load_val,
        input  q, busy, tc, done
    );

    modport slave (
        input  start, stop, load_val,
        output q, busy, tc, done
    );

endinterface

// File: rtl/down_cnt_core.sv
// down_cnt_core
// WIDTH-bit loadable down counter; the datapath of down_timer_ctrl.
//   clk, reset : clock and asynchronous active-high reset
//   load, d    : load d into q (has priority over dec)
//   dec        : decrement q by one; saturates at zero
//   q          : registered count
module down_cnt_core
    import down_timer_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (dec && (q != '0)) begin
            q <= q - WIDTH'(1);
        end
    end

endmodule

// File: rtl/down_timer_ctrl.sv
// down_timer_ctrl
// Prescaled down timer with a three-state controller.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : down_timer_ctrl_if.slave (start, stop, load_val in;
//                q, busy, tc, done out, all registered)
// Parameters: WIDTH (count width), PRESCALE (clock cycles per tick, >= 1).
// Build option: define AUTO_RELOAD_EN to reload the count from the value
// captured at start each time it expires, instead of stopping in DONE.
//
// state | meaning
// IDLE  | stopped, q holds its last value
// RUN   | counting down one step per prescaler tick
// DONE  | count expired, q = 0
module down_timer_ctrl
    import down_timer_ctrl_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PRESCALE = 1
) (
    input  logic           clk,
    input  logic           reset,
    down_timer_ctrl_if.slave bus
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    state_t           state, state_n;
    logic [PW-1:0]    presc, presc_n;
    logic             tc_n;
    logic             ld;
    logic             dec;
    logic             tick;
    logic [WIDTH-1:0] ld_d;
`ifdef AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_reg, reload_n;
`endif

    assign tick = (state == RUN) && (presc == PRESC_LAST);

    always_comb begin
        state_n = state;
        presc_n = presc;
        tc_n    = 1'b0;
        ld      = 1'b0;
        dec     = 1'b0;
        ld_d    = bus.load_val;
`ifdef AUTO_RELOAD_EN
        reload_n = reload_reg;
`endif
        if (bus.stop) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        ld      = 1'b1;
                        presc_n = '0;
`ifdef AUTO_RELOAD_EN
                        reload_n = bus.load_val;
`endif
                        // A zero start value expires immediately.
                        if (bus.load_val == '0) begin
                            tc_n    = 1'b1;
                            state_n = DONE;
                        end else begin
                            state_n = RUN;
                        end
                    end
                end
                RUN: begin
                    if (tick) begin
                        presc_n = '0;
`ifdef AUTO_RELOAD_EN
                        if (bus.q == '0) begin
                            ld   = 1'b1;
                            ld_d = reload_reg;
                        end else begin
                            dec  = 1'b1;
                            tc_n = (bus.q == WIDTH'(1));
                        end
`else
                        if (bus.q != '0) begin
                            dec = 1'b1;
                        end
                        if (bus.q == WIDTH'(1)) begin
                            tc_n = 1'b1;
                        end
                        // q == 0 in RUN is unreachable; leave cleanly if it happens.
                        if (bus.q <= WIDTH'(1)) begin
                            state_n = DONE;
                        end
`endif
                    end else begin
                        presc_n = presc + PW'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            presc    <= '0;
            bus.tc   <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            state    <= state_n;
            presc    <= presc_n;
            bus.tc   <= tc_n;
            bus.busy <= (state_n == RUN);
            bus.done <= (state_n == DONE);
        end
    end

`ifdef AUTO_RELOAD_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reload_reg <= '0;
        end else begin
            reload_reg <= reload_n;
        end
    end
`endif

    down_cnt_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .reset (reset),
        .load  (ld),
        .dec   (dec),
        .d     (ld_d),
        .q     (bus.q)
    );

endmodule

// File: tb/tb_down_timer_ctrl.sv
// tb_down_timer_ctrl
// Bench for down_timer_ctrl: two instances (PRESCALE=1 and PRESCALE=3) share
// the same request inputs; a cycle-level reference model tracks both.
module tb_down_timer_ctrl;
    import down_timer_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, stop;
    logic [3:0] lv;

    always #5 clk = ~clk;

    down_timer_ctrl_if #(.WIDTH(4)) b1 ();
    down_timer_ctrl_if #(.WIDTH(4)) b3 ();

    assign b1.start = start;
    assign b1.stop = stop;
    assign b1.load_val = lv;
    assign b3.start = start;
    assign b3.stop = stop;
    assign b3.load_val = lv;

    down_timer_ctrl #(.WIDTH(4), .PRESCALE(1)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));
    down_timer_ctrl #(.WIDTH(4), .PRESCALE(3)) u3 (.clk(clk), .reset(reset), .bus(b3.slave));

    int total = 0;
    int bad = 0;

    // Reference model: mode 0=stopped, 1=counting, 2=expired.
    int m_mode[2];
    int m_q[2];
    int m_cyc[2];
    int m_rl[2];
    int m_tc[2];
    int pre[2] = '{1, 3};

    typedef struct {
        logic       st;
        logic       sp;
        logic [3:0] lv;
        logic [3:0] q;
        logic       b;
        logic       t;
        logic       d;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(logic st, logic sp, logic [3:0] l, logic [3:0] q,
                                logic b, logic t, logic d);
        vec_t v;
        v = '{st, sp, l, q, b, t, d};
        vecs.push_back(v);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_q[i] = 0; m_cyc[i] = 0; m_rl[i] = 0; m_tc[i] = 0;
        end
    endfunction

    // Advance the model by one clock edge using the request inputs seen there.
    function automatic void model_step();
        for (int i = 0; i < 2; i++) begin
            m_tc[i] = 0;
            if (stop) begin
                m_mode[i] = 0;
            end else if (m_mode[i] != 1 && start) begin
                m_rl[i] = int'(lv);
                m_cyc[i] = 0;
                if (lv == 0) begin
                    m_q[i] = 0; m_tc[i] = 1; m_mode[i] = 2;
                end else begin
                    m_q[i] = int'(lv); m_mode[i] = 1;
                end
            end else if (m_mode[i] == 1) begin
                m_cyc[i] = m_cyc[i] + 1;
                if (m_cyc[i] == pre[i]) begin
                    m_cyc[i] = 0;
`ifdef AUTO_RELOAD_EN
                    if (m_q[i] == 0) begin
                        m_q[i] = m_rl[i];
                    end else begin
                        m_q[i] = m_q[i] - 1;
                        m_tc[i] = (m_q[i] == 0) ? 1 : 0;
                    end
`else
                    m_q[i] = m_q[i] - 1;
                    if (m_q[i] == 0) begin
                        m_tc[i] = 1; m_mode[i] = 2;
                    end
`endif
                end
            end
        end
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_model();
        check("u1.q", 32'(b1.q), m_q[0]);
        check("u1.busy", 32'(b1.busy), (m_mode[0] == 1) ? 1 : 0);
        check("u1.tc", 32'(b1.tc), m_tc[0]);
        check("u1.done", 32'(b1.done), (m_mode[0] == 2) ? 1 : 0);
        check("u3.q", 32'(b3.q), m_q[1]);
        check("u3.busy", 32'(b3.busy), (m_mode[1] == 1) ? 1 : 0);
        check("u3.tc", 32'(b3.tc), m_tc[1]);
        check("u3.done", 32'(b3.done), (m_mode[1] == 2) ? 1 : 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk_model();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp3[6] = '{2, 2, 1, 1, 1, 0};

        start = 1'b0; stop = 1'b0; lv = 4'd0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        model_reset();
        check("rst.q", 32'(b1.q), 0);
        check("rst.busy", 32'(b1.busy), 0);
        check("rst.tc", 32'(b1.tc), 0);
        check("rst.done", 32'(b1.done), 0);
        @(negedge clk);
        reset = 1'b0;

`ifdef AUTO_RELOAD_EN
        add(1, 0, 3, 3, 1, 0, 0);
        add(0, 0, 0, 2, 1, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 3, 1, 0, 0);
        add(0, 0, 0, 2, 1, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0);
        add(1, 0, 9, 3, 1, 0, 0);
        add(0, 1, 0, 3, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0);
`else
        add(1, 0, 5, 5, 1, 0, 0);
        add(0, 0, 0, 4, 1, 0, 0);
        add(0, 0, 0, 3, 1, 0, 0);
        add(0, 0, 0, 2, 1, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 9, 9, 1, 0, 0);
        add(0, 0, 0, 8, 1, 0, 0);
        add(0, 0, 0, 7, 1, 0, 0);
        add(0, 0, 0, 6, 1, 0, 0);
        add(0, 0, 0, 5, 1, 0, 0);
        add(0, 0, 0, 4, 1, 0, 0);
        add(0, 0, 0, 3, 1, 0, 0);
        add(0, 1, 0, 3, 0, 0, 0);
        add(1, 1, 7, 3, 0, 0, 0);
        add(1, 0, 7, 7, 1, 0, 0);
        add(1, 0, 2, 6, 1, 0, 0);
        add(0, 1, 0, 6, 0, 0, 0);
`endif
        foreach (vecs[i]) begin
            start = vecs[i].st; stop = vecs[i].sp; lv = vecs[i].lv;
            step();
            check($sformatf("vec%0d.q", i), 32'(b1.q), 32'(vecs[i].q));
            check($sformatf("vec%0d.busy", i), 32'(b1.busy), 32'(vecs[i].b));
            check($sformatf("vec%0d.tc", i), 32'(b1.tc), 32'(vecs[i].t));
            check($sformatf("vec%0d.done", i), 32'(b1.done), 32'(vecs[i].d));
        end
        start = 1'b0; stop = 1'b0;

        // Prescaled run: simultaneous start+stop stays idle, then load 2.
        stop = 1'b1; step();
        start = 1'b1; lv = 4'd2; step();
        check("ss.busy", 32'(b3.busy), 0);
        check("ss.done", 32'(b3.done), 0);
        stop = 1'b0; step();
        check("p3.load", 32'(b3.q), 2);
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("p3.q%0d", k + 1), 32'(b3.q), 32'(exp3[k]));
            check($sformatf("p3.tc%0d", k + 1), 32'(b3.tc), (k == 5) ? 1 : 0);
        end
        step();
        check("p3.tc_after", 32'(b3.tc), 0);

        // Asynchronous reset in the middle of a run.
        stop = 1'b1; step();
        stop = 1'b0; start = 1'b1; lv = 4'd6; step();
        start = 1'b0; step(); step();
        check("ar.pre_q", 32'(b1.q), 4);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("ar.q", 32'(b1.q), 0);
        check("ar.busy", 32'(b1.busy), 0);
        check("ar.done", 32'(b1.done), 0);
        check("ar.q3", 32'(b3.q), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            check("ar.no_tc", 32'(b1.tc | b3.tc), 0);
        end

        // Random requests against the model.
        for (int n = 0; n < 400; n++) begin
            start = ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 9) == 0);
            lv = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/down_timer_ctrl.md
DOWN_TIMER_CTRL -- requirements
Module: down_timer_ctrl

Interface
- REQ-001: Parameter WIDTH, default 4, sets the count width in bits.
- REQ-002: Parameter PRESCALE, default 1, sets clock cycles per count tick; legal range is 1 or more.
- REQ-003: clk, input, 1 bit: the single clock; all state is updated on its rising edge.
- REQ-004: reset, input, 1 bit: asynchronous, active-high reset.
- REQ-005: start, input, 1 bit: load and run request, sampled on clk.
- REQ-006: stop, input, 1 bit: abort request, sampled on clk.
- REQ-007: load_val, input, WIDTH bits: start count, captured when start is accepted.
- REQ-008: q, output, WIDTH bits: current count value, registered.
- REQ-009: busy, output, 1 bit: high while in RUN.
- REQ-010: tc, output, 1 bit: terminal-count pulse, exactly one cycle wide.
- REQ-011: done, output, 1 bit: high while in DONE.

Function
- REQ-012: The FSM SHALL have three states: IDLE, RUN and DONE; all outputs SHALL be registered.
- REQ-013: A tick is a cycle in which the prescale counter equals PRESCALE-1; that counter wraps to 0 on a tick; with PRESCALE=1, every RUN cycle is a tick.
- REQ-014: IDLE with start=1 and stop=0: on the next edge, q<=load_val, load_val is stored in reload_reg, the prescaler clears, and the FSM enters RUN.
- REQ-015: IDLE with start=1 and load_val=0: on the next edge, q<=0, tc=1 and the FSM enters DONE, bypassing RUN.
- REQ-016: RUN, tick, q>1: q decrements by 1.
- REQ-017: RUN, tick, q==1: q<=0, tc=1 on that same edge, and the FSM enters DONE (non-reload build).
- REQ-018: RUN, no tick: q holds.
- REQ-019: stop has priority over start and tick in every state: on the next edge the FSM enters IDLE, q holds its value and tc stays 0.
- REQ-020: start is ignored while in RUN; a restart requires stop followed by start.
- REQ-021: DONE with start=1: same action as REQ-014; otherwise DONE holds with q=0.
- REQ-022: q SHALL never wrap below 0 in the non-reload build.

Reset
- REQ-023: reset=1 SHALL immediately force state=IDLE, q=0, tc=0, busy=0, done=0, prescaler=0 and reload_reg=0, independent of clk.
- REQ-024: reset asserted mid-RUN SHALL abort the run; after reset deasserts, no tc is produced until a new start.

Configuration
- REQ-025: Macro AUTO_RELOAD_EN SHALL control auto-reload.
- REQ-026: With AUTO_RELOAD_EN defined:
  - A tick in RUN with q==0 loads q<=reload_reg and stays in RUN.
  - tc pulses on the edge where q becomes 0.
  - The period is reload_reg+1 ticks.
  - DONE is unreachable except via REQ-015.
- REQ-027: Without AUTO_RELOAD_EN, behaviour SHALL be exactly REQ-012 to REQ-022, and reload_reg MAY be optimised away.

Structure
- REQ-028: A shared package SHALL hold the state enum type (IDLE, RUN, DONE) and the default WIDTH constant.
- REQ-029: The datapath SHALL be a single sub-module, down_cnt_core, containing the WIDTH-bit loadable down counter (load, dec, d, q).
- REQ-030: down_timer_ctrl SHALL hold the FSM, the prescaler and reload_reg.

Verification (WIDTH=4, PRESCALE=1 unless stated)
- REQ-031: load_val=5, one-cycle start -> q sequence 5,4,3,2,1,0 on consecutive edges; tc=1 only in the cycle q=0; done=1 from then on; busy=1 for 5 cycles.
- REQ-032: load_val=0 with start -> one edge later: q=0, tc=1 for one cycle, done=1, busy never high.
- REQ-033: load_val=9, start, then stop held while q=3 -> IDLE, q holds 3, busy=0, no tc; a subsequent start with load_val=7 gives q=7.
- REQ-034: load_val=6, reset pulsed mid-edge at q=4 -> q=0, busy=0 and done=0 immediately, without waiting for clk; no tc after reset release.
- REQ-035: PRESCALE=3, load_val=2 -> q changes every 3 cycles; tc fires 6 cycles after the load edge; simultaneous start and stop in IDLE keep the FSM in IDLE.
- REQ-036: AUTO_RELOAD_EN defined, load_val=3 -> q sequence 3,2,1,0,3,2,1,0 …; tc pulses every 4 cycles; done stays 0; stop returns the FSM to IDLE.
